// File: rtl/clock_controller_if.sv
// clock_controller_if
//   Bundles the tick and button event pulses together with the time, mode and
//   field-visibility outputs of the clock controller.
//   master : drives the pulses and observes the outputs (clock divider, buttons, display)
//   slave  : the controller; receives the pulses and drives the outputs
//   tick_1hz / tick_500ms        divider pulses, one cycle wide
//   mode_p / inc_p / dec_p       debounced button pulses, one cycle wide
//   hours[4:0] minutes[5:0] seconds[5:0] current time, binary
//   mode[1:0]                    0=RUN 1=SET_HOUR 2=SET_MIN
//   hour_vis / min_vis           1 = show that field's digits
interface clock_controller_if;
    logic       tick_1hz;
    logic       tick_500ms;
    logic       mode_p;
    logic       inc_p;
    logic       dec_p;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       hour_vis;
    logic       min_vis;

    modport master (
        output tick_1hz, tick_500ms, mode_p, inc_p, dec_p,
        input  hours, minutes, seconds, mode, hour_vis, min_vis
    );

    modport slave (
        input  tick_1hz, tick_500ms, mode_p, inc_p, dec_p,
        output hours, minutes, seconds, mode, hour_vis, min_vis
    );
endinterface

// File: rtl/clock_controller.sv
// clock_controller
//   Keeps hours/minutes/seconds, sequences RUN -> SET_HOUR -> SET_MIN -> RUN on
//   the mode button, applies inc/dec edits in the SET modes, and blinks the
//   field under edit through hour_vis/min_vis. Every output is a register, so
//   an input event shows up the cycle after the edge that samples it.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : clock_controller_if.slave (pulses in, time/mode/visibility out)
module clock_controller #(
    parameter int unsigned HOUR_MOD = 24,
    parameter int unsigned MIN_MOD  = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_controller_if.slave     bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    localparam logic [4:0] HOUR_MAX = 5'(HOUR_MOD - 1);
    localparam logic [5:0] MIN_MAX  = 6'(MIN_MOD - 1);

    mode_t      state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic       blink_q, blink_d;
    logic       hour_vis_q, hour_vis_d;
    logic       min_vis_q, min_vis_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            hours_q    <= '0;
            minutes_q  <= '0;
            seconds_q  <= '0;
            blink_q    <= 1'b1;
            hour_vis_q <= 1'b1;
            min_vis_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            blink_q    <= blink_d;
            hour_vis_q <= hour_vis_d;
            min_vis_q  <= min_vis_d;
        end
    end

    // Next mode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (bus.mode_p) state_d = SET_HOUR;
            SET_HOUR: if (bus.mode_p) state_d = SET_MIN;
            SET_MIN:  if (bus.mode_p) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Time counters, blink and visibility for the next cycle
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        blink_d   = blink_q;
        unique case (state_q)
            RUN: begin
                blink_d = 1'b1;
                if (bus.tick_1hz) begin
                    if (seconds_q == MIN_MAX) begin
                        seconds_d = '0;
                        if (minutes_q == MIN_MAX) begin
                            minutes_d = '0;
                            hours_d   = (hours_q == HOUR_MAX) ? '0 : hours_q + 5'd1;
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end
                // Entering SET_HOUR clears seconds, overriding a same-cycle tick.
                if (bus.mode_p) seconds_d = '0;
            end
            SET_HOUR: begin
                if (bus.mode_p) begin
                    blink_d = 1'b1;
                end else if (bus.inc_p) begin
                    hours_d = (hours_q == HOUR_MAX) ? '0 : hours_q + 5'd1;
                    blink_d = 1'b1;
                end else if (bus.dec_p) begin
                    hours_d = (hours_q == '0) ? HOUR_MAX : hours_q - 5'd1;
                    blink_d = 1'b1;
                end else if (bus.tick_500ms) begin
                    blink_d = ~blink_q;
                end
            end
            SET_MIN: begin
                // Minute wrap here never touches hours.
                if (bus.mode_p) begin
                    blink_d = 1'b1;
                end else if (bus.inc_p) begin
                    minutes_d = (minutes_q == MIN_MAX) ? '0 : minutes_q + 6'd1;
                    blink_d   = 1'b1;
                end else if (bus.dec_p) begin
                    minutes_d = (minutes_q == '0) ? MIN_MAX : minutes_q - 6'd1;
                    blink_d   = 1'b1;
                end else if (bus.tick_500ms) begin
                    blink_d = ~blink_q;
                end
            end
            default: blink_d = 1'b1;
        endcase
        // Visibility is registered from next-cycle mode/blink so it lines up
        // with the mode output.
        hour_vis_d = !((state_d == SET_HOUR) && !blink_d);
        min_vis_d  = !((state_d == SET_MIN) && !blink_d);
    end

    assign bus.hours    = hours_q;
    assign bus.minutes  = minutes_q;
    assign bus.seconds  = seconds_q;
    assign bus.mode     = state_q;
    assign bus.hour_vis = hour_vis_q;
    assign bus.min_vis  = min_vis_q;

endmodule

// File: tb/tb_clock_controller.sv
// tb_clock_controller
//   Directed vector table (with repeat counts for long tick runs) followed by
//   randomized pulses checked against a wall-clock style reference model.
module tb_clock_controller;

    localparam int HM = 24;
    localparam int MM = 60;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clock_controller_if bus ();

    clock_controller #(.HOUR_MOD(HM), .MIN_MOD(MM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int rep;
        bit rst, t1, t5, mp, ip, dp;
        int h, m, s, md;
        bit hv, mv;
    } vec_t;

    vec_t vecs[$];
    int errors = 0;
    int checks = 0;

    // Reference model state
    int  rh, rm, rs, rmode;
    bit  rblink;

    function automatic vec_t row(int rep, bit r, bit t1, bit t5, bit mp, bit ip, bit dp,
                                 int h, int m, int s, int md, bit hv, bit mv);
        vec_t v;
        v.rep = rep; v.rst = r; v.t1 = t1; v.t5 = t5; v.mp = mp; v.ip = ip; v.dp = dp;
        v.h = h; v.m = m; v.s = s; v.md = md; v.hv = hv; v.mv = mv;
        return v;
    endfunction

    task automatic drive(bit r, bit t1, bit t5, bit mp, bit ip, bit dp);
        rst = r;
        bus.tick_1hz = t1; bus.tick_500ms = t5;
        bus.mode_p = mp; bus.inc_p = ip; bus.dec_p = dp;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.tick_1hz = 1'b0; bus.tick_500ms = 1'b0;
        bus.mode_p = 1'b0; bus.inc_p = 1'b0; bus.dec_p = 1'b0;
    endtask

    task automatic compare(string name, int idx, int h, int m, int s, int md, bit hv, bit mv);
        checks++;
        if (int'(bus.hours) != h || int'(bus.minutes) != m || int'(bus.seconds) != s ||
            int'(bus.mode) != md || bus.hour_vis != hv || bus.min_vis != mv) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d:%0d:%0d mode=%0d hv=%0d mv=%0d, expected %0d:%0d:%0d mode=%0d hv=%0d mv=%0d",
                     name, idx, bus.hours, bus.minutes, bus.seconds, bus.mode, bus.hour_vis, bus.min_vis,
                     h, m, s, md, hv, mv);
        end
    endtask

    // Reference: time as a count of seconds since midnight; edits as modular arithmetic.
    task automatic model_step(bit r, bit t1, bit t5, bit mp, bit ip, bit dp);
        int total;
        if (r) begin
            rh = 0; rm = 0; rs = 0; rmode = 0; rblink = 1;
            return;
        end
        if (rmode == 0) begin
            if (t1) begin
                total = ((rh * MM + rm) * MM + rs + 1) % (HM * MM * MM);
                rh = total / (MM * MM);
                rm = (total / MM) % MM;
                rs = total % MM;
            end
            if (mp) begin rs = 0; rmode = 1; end
            rblink = 1;
        end else if (mp) begin
            rmode = (rmode == 1) ? 2 : 0;
            rblink = 1;
        end else if (ip || dp) begin
            if (rmode == 1) rh = (rh + (ip ? 1 : HM - 1)) % HM;
            else            rm = (rm + (ip ? 1 : MM - 1)) % MM;
            rblink = 1;
        end else if (t5) begin
            rblink = !rblink;
        end
    endtask

    initial begin
        bus.tick_1hz = 0; bus.tick_500ms = 0; bus.mode_p = 0; bus.inc_p = 0; bus.dec_p = 0;

        //                rep rst t1 t5 mp ip dp   h   m   s md hv mv
        vecs.push_back(row(  2, 1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 1, 1)); // reset
        vecs.push_back(row(  1, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 1, 1));
        vecs.push_back(row(  5, 0, 1, 0, 0, 0, 0,  0,  0,  5, 0, 1, 1));
        vecs.push_back(row(  1, 0, 0, 0, 1, 0, 0,  0,  0,  0, 1, 1, 1)); // SET_HOUR clears secs
        vecs.push_back(row(  1, 0, 0, 0, 0, 0, 1, 23,  0,  0, 1, 1, 1)); // dec wraps 0->23
        vecs.push_back(row(  1, 0, 0, 0, 1, 0, 0, 23,  0,  0, 2, 1, 1));
        vecs.push_back(row(  1, 0, 0, 0, 0, 0, 1, 23, 59,  0, 2, 1, 1)); // no borrow from hours
        vecs.push_back(row(  1, 0, 0, 0, 0, 0, 1, 23, 58,  0, 2, 1, 1));
        vecs.push_back(row(  1, 0, 0, 0, 1, 0, 0, 23, 58,  0, 0, 1, 1));
        vecs.push_back(row(118, 0, 1, 0, 0, 0, 0, 23, 59, 58, 0, 1, 1));
        vecs.push_back(row(  1, 0, 1, 0, 0, 0, 0, 23, 59, 59, 0, 1, 1));
        vecs.push_back(row(  1, 0, 1, 0, 0, 0, 0,  0,  0,  0, 0, 1, 1)); // full rollover
        vecs.push_back(row(  1, 0, 0, 0, 1, 0, 0,  0,  0,  0, 1, 1, 1));
        vecs.push_back(row(  1, 0, 0, 0, 0, 0, 1, 23,  0,  0, 1, 1, 1));
        vecs.push_back(row(  1, 0, 1, 0, 0, 0, 0, 23,  0,  0, 1, 1, 1)); // frozen in SET
        vecs.push_back(row(  1, 0, 0, 1, 0, 0, 0, 23,  0,  0, 1, 0, 1)); // blink 0,1,0
        vecs.push_back(row(  1, 0, 0, 1, 0, 0, 0, 23,  0,  0, 1, 1, 1));
        vecs.push_back(row(  1, 0, 0, 1, 0, 0, 0, 23,  0,  0, 1, 0, 1));
        vecs.push_back(row(  1, 0, 0, 1, 0, 1, 0,  0,  0,  0, 1, 1, 1)); // adjust beats blink
        vecs.push_back(row(  1, 0, 0, 0, 1, 0, 0,  0,  0,  0, 2, 1, 1));
        vecs.push_back(row(  1, 0, 0, 0, 0, 0, 1,  0, 59,  0, 2, 1, 1));
        vecs.push_back(row(  1, 0, 0, 0, 0, 1, 0,  0,  0,  0, 2, 1, 1)); // no carry into hours
        vecs.push_back(row(  1, 0, 1, 0, 0, 0, 0,  0,  0,  0, 2, 1, 1));
        vecs.push_back(row(  1, 0, 0, 1, 0, 0, 0,  0,  0,  0, 2, 1, 0));
        vecs.push_back(row(  1, 0, 0, 0, 1, 0, 0,  0,  0,  0, 0, 1, 1));
        vecs.push_back(row(  3, 0, 1, 0, 0, 0, 0,  0,  0,  3, 0, 1, 1));
        vecs.push_back(row(  1, 0, 1, 0, 1, 0, 0,  0,  0,  0, 1, 1, 1)); // tick+mode -> secs 0
        vecs.push_back(row(  1, 0, 0, 0, 1, 1, 0,  0,  0,  0, 2, 1, 1)); // mode beats inc
        vecs.push_back(row( 10, 0, 0, 0, 0, 1, 0,  0, 10,  0, 2, 1, 1));
        vecs.push_back(row(  1, 0, 0, 0, 0, 1, 1,  0, 11,  0, 2, 1, 1)); // inc beats dec
        vecs.push_back(row(  1, 0, 0, 0, 1, 0, 0,  0, 11,  0, 0, 1, 1));
        vecs.push_back(row(  1, 0, 0, 0, 1, 0, 0,  0, 11,  0, 1, 1, 1));
        vecs.push_back(row(  5, 0, 0, 0, 0, 1, 0,  5, 11,  0, 1, 1, 1));
        vecs.push_back(row(  1, 0, 0, 0, 1, 0, 0,  5, 11,  0, 2, 1, 1));
        vecs.push_back(row(  1, 0, 0, 1, 0, 0, 0,  5, 11,  0, 2, 1, 0));
        vecs.push_back(row(  1, 1, 0, 0, 1, 1, 0,  0,  0,  0, 0, 1, 1)); // reset mid-set wins

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++)
                drive(vecs[i].rst, vecs[i].t1, vecs[i].t5, vecs[i].mp, vecs[i].ip, vecs[i].dp);
            compare("vec", i, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].md, vecs[i].hv, vecs[i].mv);
        end

        // Hand sequence: a reset pulse mid-adjust followed by an idle cycle
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0);
        compare("rst_mid_set", 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        compare("after_rst", 0, 0, 0, 0, 0, 1, 1);

        // Randomized phase against the reference model, starting from reset state
        model_step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit r, t1, t5, mp, ip, dp;
            r  = ($urandom_range(0, 199) == 0);
            t1 = ($urandom_range(0, 2) == 0);
            t5 = ($urandom_range(0, 3) == 0);
            mp = ($urandom_range(0, 9) == 0);
            ip = ($urandom_range(0, 3) == 0);
            dp = ($urandom_range(0, 3) == 0);
            drive(r, t1, t5, mp, ip, dp);
            model_step(r, t1, t5, mp, ip, dp);
            compare("rand", n, rh, rm, rs, rmode,
                    !(rmode == 1 && !rblink), !(rmode == 2 && !rblink));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
